ir_code_display: RTL and testbench
==================================

# ir_code_display

Parametrised IR code capture and display block, the successor to the fixed 8-digit IR-to-hex display at the top level. It sits between the IR frame receiver and the seven-segment outputs. It validates NEC checksums, filters repeat frames, and keeps a history of the last DEPTH codes. It drives DIGITS seven-segment digits in one of four display modes, with a blanking timeout.

## Interface
- DIGITS, 8: number of seven-segment digits driven (1..8)
- DEPTH, 4: history entries (power of two, 2..16)
- TIMEOUT_CYCLES, 100_000_000: idle cycles before live display blanks
- COMMON_ANODE, 1: 1 = segments active-low, 0 = active-high

Ports:
- i_CLOCK_POS  in  1  sole clock, rising edge
- i_RESET_POS  in  1  synchronous, active-high reset
- i_DATA_READY  in  1  one-cycle pulse from IR receiver
- i_DATA  in  32  frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
- i_MODE  in  2  00 raw, 01 addr/cmd, 10 error count, 11 history
- i_SELECT_STEP  in  1  pulse, advance history index
- i_CLEAR  in  1  pulse, flush history and counters
- o_SEVEN_SEGMENT  out  7*DIGITS  digit k at [7k+6:7k], bit order gfedcba
- o_FRAME_VALID  out  1  pulse, new valid frame committed
- o_ERROR  out  1  pulse, checksum fail or overrun
- o_REPEAT  out  1  pulse, repeat frame detected
- o_COUNT  out  $clog2(DEPTH+1)  stored history entries

## Operation
- FSM states: IDLE, CHECK, COMMIT.
  - IDLE: on i_DATA_READY, latch i_DATA and go to CHECK.
  - CHECK: evaluate addr^~addr==8'hFF and cmd^~cmd==8'hFF, then go to COMMIT.
  - COMMIT: act on the result, then return to IDLE.
- Fail in COMMIT: o_ERROR=1, error counter +1, history untouched.
- Repeat: the frame is valid, equals the newest entry, and the timeout has not expired. Result: o_REPEAT=1, timeout counter restarted, no push.
- Otherwise: push to the circular buffer, o_FRAME_VALID=1, timeout counter restarted.
- Full buffer: the newest entry overwrites the oldest; o_COUNT saturates at DEPTH.
- i_DATA_READY outside IDLE: frame dropped, o_ERROR pulse, error counter +1.
- Error counter: 16 bits, saturates at 16'hFFFF.
- History index: 0 = newest. i_SELECT_STEP increments it modulo o_COUNT; no effect when empty. The index resets to 0 on every push.
- Display word, 32 bits; digit k shows nibble k:
  - 00: newest frame
  - 01: {16'h0, addr, cmd}
  - 10: {16'h0, err_cnt}
  - 11: entry[index]
- Blanking: all segments off (7'h7F anode / 7'h00 cathode) when:
  - history is empty in modes 00, 01, 11, or
  - the timeout has expired in modes 00 and 01.
- i_CLEAR: empties history, zeroes the error counter and index, and expires the timeout.
- i_CLEAR during COMMIT: clear wins, the frame is discarded, no output pulse.
- Reset values:
  - state IDLE
  - o_COUNT 0, o_FRAME_VALID/o_ERROR/o_REPEAT 0
  - error counter 0, timeout expired
  - o_SEVEN_SEGMENT all blank

## Timing
- i_DATA_READY at cycle n: pulse outputs at n+2 for exactly one cycle. o_COUNT and the display reflect the frame at n+3 (registered outputs).
- i_SELECT_STEP at n: display changes at n+2.
- i_MODE change at n: display changes at n+1.
- Timeout expires TIMEOUT_CYCLES cycles after the last commit or repeat, and the blank is visible the next cycle.
- Reset asserted in any state: all state is at reset values the following cycle; an in-flight frame is lost with no pulse.

## Configuration
- IR_DISPLAY_LEADING_ZERO_BLANK_EN
  - Defined: zero digits above the highest non-zero digit are blanked; digit 0 always shows.
  - Undefined: all DIGITS digits show, including leading zeros.

## Structure
- Package ir_display_pkg:
  - mode encodings, FSM state enum
  - NEC field bit positions
  - 16-entry hex-to-gfedcba segment constant table
- Sub-module ir_display_digit: nibble + blank + COMMON_ANODE to 7-bit segments, instantiated DIGITS times.

## Test plan
- Valid frame, mode 00, DIGITS=8: 32'h00FF_A25D at n -> o_FRAME_VALID at n+2; digit0 'D', digit7 '0' = 7'h40 (anode); o_COUNT=1.
- Bad checksum, mode 10: 32'h00FF_A25C -> o_ERROR at n+2; display 00000001; o_COUNT unchanged.
- Repeat: 32'h00FF_A25D twice, 50 cycles apart, TIMEOUT_CYCLES=100 -> second gives o_REPEAT, o_COUNT=1.
- Wrap, DEPTH=4, mode 11: push codes cmd 01..05 -> o_COUNT=4; four steps show cmd 05,04,03,02, then 05 again.
- Timeout, mode 00, TIMEOUT_CYCLES=100: 100 idle cycles after commit -> all digits 7'h7F. Mode 11 in the same state is still displayed.
- Reset/clear: i_RESET_POS in CHECK -> no pulses, o_COUNT=0, display blank. i_CLEAR coincident with COMMIT -> frame discarded, o_COUNT=0.

Source files
------------

// File: rtl/ir_display_pkg.sv
// Shared definitions for the IR code display: mode and FSM encodings,
// NEC frame field positions, a hex-to-segment table and a checksum helper.
// Segment patterns are active-high gfedcba; the digit driver inverts them for common-anode parts.
package ir_display_pkg;

  typedef enum logic [1:0] {
    MODE_RAW      = 2'b00,
    MODE_ADDR_CMD = 2'b01,
    MODE_ERR_CNT  = 2'b10,
    MODE_HISTORY  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

  // NEC frame layout: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd
  localparam int NEC_ADDR_LSB  = 24;
  localparam int NEC_NADDR_LSB = 16;
  localparam int NEC_CMD_LSB   = 8;
  localparam int NEC_NCMD_LSB  = 0;

  // Active-high gfedcba patterns for 0..F (lower-case b and d)
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // A frame is valid when each byte is the bitwise complement of its partner.
  function automatic logic nec_ok(input logic [31:0] frame);
    logic addr_ok;
    logic cmd_ok;
    addr_ok = ((frame[NEC_ADDR_LSB +: 8] ^ frame[NEC_NADDR_LSB +: 8]) == 8'hFF);
    cmd_ok  = ((frame[NEC_CMD_LSB +: 8]  ^ frame[NEC_NCMD_LSB +: 8])  == 8'hFF);
    return addr_ok && cmd_ok;
  endfunction

endpackage

// File: rtl/ir_display_digit.sv
// One seven-segment digit: hex nibble to gfedcba with blanking and output polarity.
// Latency: purely combinational (the top registers all digits together).
// Ports: nibble_i (value), blank_i (force all segments off), seg_o (gfedcba, polarity per COMMON_ANODE).
module ir_display_digit
  import ir_display_pkg::*;
#(
  parameter int COMMON_ANODE = 1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_on;

  always_comb begin
    seg_on = SEG_HEX[nibble_i];
    if (blank_i) begin
      seg_on = 7'h00;
    end
    seg_o = (COMMON_ANODE != 0) ? ~seg_on : seg_on;
  end

endmodule

// File: rtl/ir_code_display.sv
// IR code capture/display: NEC checksum check, repeat filter, DEPTH-entry history, DIGITS-digit display.
// Latency: pulses two cycles after i_DATA_READY; o_COUNT/display one cycle later; mode change one cycle.
// No backpressure: a frame arriving while the FSM is busy is dropped and flagged on o_ERROR.
//
// Ports: i_CLOCK_POS clock; i_RESET_POS sync active-high reset; i_DATA_READY/i_DATA frame input;
//        i_MODE display mode; i_SELECT_STEP history index step; i_CLEAR flush history and counters;
//        o_SEVEN_SEGMENT digit k at [7k+6:7k]; o_FRAME_VALID/o_ERROR/o_REPEAT event pulses;
//        o_COUNT number of stored history entries.
// Build option: define IR_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module ir_code_display
  import ir_display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int COMMON_ANODE   = 1
) (
  input  logic                         i_CLOCK_POS,
  input  logic                         i_RESET_POS,
  input  logic                         i_DATA_READY,
  input  logic [31:0]                  i_DATA,
  input  logic [1:0]                   i_MODE,
  input  logic                         i_SELECT_STEP,
  input  logic                         i_CLEAR,
  output logic [7*DIGITS-1:0]          o_SEVEN_SEGMENT,
  output logic                         o_FRAME_VALID,
  output logic                         o_ERROR,
  output logic                         o_REPEAT,
  output logic [$clog2(DEPTH+1)-1:0]   o_COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [6:0]    SEG_OFF    = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

  // ---------------------------------------------------------------- state
  state_e              state_q, state_d;
  logic [31:0]         frame_q, frame_d;
  logic                pass_q, pass_d;
  logic [31:0]         hist_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [15:0]         err_q, err_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                expired_q, expired_d;
  logic                ovr1_q, ovr1_d;
  logic                ovr2_q, ovr2_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  // ---------------------------------------------------------------- commit decode
  logic          in_commit;
  logic          is_repeat;
  logic          do_push;
  logic          commit_fail;
  logic          ovr_err;
  logic [PW-1:0] newest_ptr;
  logic [PW-1:0] sel_ptr;
  logic [31:0]   newest_q;
  logic [16:0]   err_sum;
  logic [CW-1:0] idx_next;

  assign newest_ptr = wr_ptr_q - PW'(1);
  assign sel_ptr    = wr_ptr_q - PW'(1) - idx_q;
  assign newest_q   = hist_q[newest_ptr];

  // Clear and reset both kill the in-flight frame before any pulse is seen.
  assign in_commit   = (state_q == ST_COMMIT) && !i_CLEAR && !i_RESET_POS;
  assign is_repeat   = in_commit && pass_q && (count_q != '0) && !expired_q && (frame_q == newest_q);
  assign do_push     = in_commit && pass_q && !is_repeat;
  assign commit_fail = in_commit && !pass_q;
  // Overrun is reported two cycles after the dropped pulse, matching the frame path.
  assign ovr_err     = ovr2_q && !i_CLEAR && !i_RESET_POS;

  assign o_FRAME_VALID   = do_push;
  assign o_REPEAT        = is_repeat;
  assign o_ERROR         = commit_fail || ovr_err;
  assign o_COUNT         = count_q;
  assign o_SEVEN_SEGMENT = seg_q;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (i_DATA_READY) begin
          frame_d = i_DATA;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        pass_d  = nec_ok(frame_q);
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- history, counters, timeout
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    idx_d     = idx_q;
    tmo_cnt_d = tmo_cnt_q;
    expired_d = expired_q;
    ovr1_d    = i_DATA_READY && (state_q != ST_IDLE) && !i_CLEAR;
    ovr2_d    = ovr1_q && !i_CLEAR;

    err_sum = {1'b0, err_q} + 17'(commit_fail) + 17'(ovr_err);
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    if (!expired_q) begin
      if (tmo_cnt_q == TMO_LAST) begin
        expired_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    idx_next = CW'(idx_q) + CW'(1);
    if (i_SELECT_STEP && (count_q != '0)) begin
      idx_d = (idx_next >= count_q) ? '0 : idx_next[PW-1:0];
    end

    if (do_push || is_repeat) begin
      tmo_cnt_d = '0;
      expired_d = 1'b0;
    end

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = (count_q == COUNT_FULL) ? count_q : count_q + 1'b1;
      idx_d    = '0;
    end

    if (i_CLEAR) begin
      wr_ptr_d  = '0;
      count_d   = '0;
      idx_d     = '0;
      err_d     = '0;
      tmo_cnt_d = '0;
      expired_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------- display word
  // Built from next-state values so the segment register tracks a commit
  // in the same edge; the history index uses its registered value, so a
  // step shows one cycle after the index moves.
  mode_e          mode;
  logic [31:0]    newest_d;
  logic [31:0]    entry_d;
  logic [31:0]    disp_word;
  logic           blank_all;
  logic [DIGITS-1:0] digit_blank;
`ifdef IR_DISPLAY_LEADING_ZERO_BLANK_EN
  logic           nonzero_above;
`endif

  always_comb begin
    mode     = mode_e'(i_MODE);
    newest_d = do_push ? frame_q : newest_q;
    entry_d  = do_push ? frame_q : hist_q[sel_ptr];
    case (mode)
      MODE_RAW:      disp_word = newest_d;
      MODE_ADDR_CMD: disp_word = {16'h0000, newest_d[NEC_ADDR_LSB +: 8], newest_d[NEC_CMD_LSB +: 8]};
      MODE_ERR_CNT:  disp_word = {16'h0000, err_d};
      MODE_HISTORY:  disp_word = entry_d;
      default:       disp_word = newest_d;
    endcase
    blank_all = ((mode != MODE_ERR_CNT) && (count_d == '0)) ||
                (((mode == MODE_RAW) || (mode == MODE_ADDR_CMD)) && expired_d);
  end

  always_comb begin
    digit_blank = {DIGITS{blank_all}};
`ifdef IR_DISPLAY_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; zeros are blanked until the first non-zero nibble.
    nonzero_above = 1'b0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      nonzero_above = nonzero_above || (disp_word[4*k +: 4] != 4'h0);
      if (!nonzero_above) begin
        digit_blank[k] = 1'b1;
      end
    end
`endif
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    ir_display_digit #(
      .COMMON_ANODE (COMMON_ANODE)
    ) u_digit (
      .nibble_i (disp_word[4*k +: 4]),
      .blank_i  (digit_blank[k]),
      .seg_o    (seg_d[7*k +: 7])
    );
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge i_CLOCK_POS) begin
    if (i_RESET_POS) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      pass_q    <= 1'b0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      tmo_cnt_q <= '0;
      expired_q <= 1'b1;
      ovr1_q    <= 1'b0;
      ovr2_q    <= 1'b0;
      seg_q     <= {DIGITS{SEG_OFF}};
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      pass_q    <= pass_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
      expired_q <= expired_d;
      ovr1_q    <= ovr1_d;
      ovr2_q    <= ovr2_d;
      seg_q     <= seg_d;
    end
  end

  // History storage needs no reset: entries are only read below o_COUNT.
  always_ff @(posedge i_CLOCK_POS) begin
    if (do_push) begin
      hist_q[wr_ptr_q] <= frame_q;
    end
  end

endmodule

// File: tb/tb_ir_code_display.sv
module tb_ir_code_display;

  localparam int DIGITS = 8;
  localparam int DEPTH  = 4;
  localparam int TMO    = 100;

  logic        clk;
  logic        rst;
  logic        data_ready;
  logic [31:0] data;
  logic [1:0]  mode;
  logic        sel_step;
  logic        clear;
  logic [55:0] seg;
  logic        fv;
  logic        err;
  logic        rep;
  logic [2:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  ir_code_display #(
    .DIGITS         (DIGITS),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO),
    .COMMON_ANODE   (1)
  ) dut (
    .i_CLOCK_POS     (clk),
    .i_RESET_POS     (rst),
    .i_DATA_READY    (data_ready),
    .i_DATA          (data),
    .i_MODE          (mode),
    .i_SELECT_STEP   (sel_step),
    .i_CLEAR         (clear),
    .o_SEVEN_SEGMENT (seg),
    .o_FRAME_VALID   (fv),
    .o_ERROR         (err),
    .o_REPEAT        (rep),
    .o_COUNT         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] frame;
    logic [1:0]  md;
    logic        e_fv;
    logic        e_err;
    logic        e_rep;
    logic [2:0]  e_count;
    logic [31:0] e_word;
  } vec_t;

  vec_t vec [10];

  // Common-anode (active-low) gfedcba patterns written out by hand.
  function automatic logic [6:0] anode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [55:0] exp_seg(input logic [31:0] w, input logic blank);
    logic [55:0] r;
    for (int k = 0; k < 8; k++) begin
      r[7*k +: 7] = blank ? 7'h7F : anode(w[4*k +: 4]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a frame for one cycle; returns one cycle after the sampling edge.
  task automatic send(input logic [31:0] f);
    data       = f;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic push(input logic [31:0] f);
    send(f);
    tick();
    tick();
  endtask

  logic [31:0] step_exp [4];

  initial begin
    rst        = 1'b1;
    data_ready = 1'b0;
    data       = '0;
    mode       = 2'b00;
    sel_step   = 1'b0;
    clear      = 1'b0;

    vec[0] = '{32'h00FF_A25D, 2'd0, 1'b1, 1'b0, 1'b0, 3'd1, 32'h00FF_A25D};
    vec[1] = '{32'h00FF_A25C, 2'd2, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0001};
    vec[2] = '{32'h00FF_A25D, 2'd1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_00A2};
    vec[3] = '{32'h10EF_01FE, 2'd3, 1'b1, 1'b0, 1'b0, 3'd2, 32'h10EF_01FE};
    vec[4] = '{32'h12ED_02FD, 2'd0, 1'b1, 1'b0, 1'b0, 3'd3, 32'h12ED_02FD};
    vec[5] = '{32'h0000_0000, 2'd2, 1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_0002};
    vec[6] = '{32'h00FF_03FC, 2'd1, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0003};
    vec[7] = '{32'h00FF_04FB, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h00FF_04FB};
    vec[8] = '{32'h00FF_04FB, 2'd3, 1'b0, 1'b0, 1'b1, 3'd4, 32'h00FF_04FB};
    vec[9] = '{32'hFF00_FF00, 2'd2, 1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0002};

    step_exp[0] = 32'h00FF_04FB;
    step_exp[1] = 32'h00FF_03FC;
    step_exp[2] = 32'h00FF_02FD;
    step_exp[3] = 32'h00FF_05FA;

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_count", count, 3'd0);
    chk("reset_pulses", {fv, err, rep}, 3'b000);
    chk("reset_seg", seg, {8{7'h7F}});

    // Table of single frames
    for (int v = 0; v < 10; v++) begin
      mode = vec[v].md;
      send(vec[v].frame);
      chk($sformatf("v%0d_pulses_n1", v), {fv, err, rep}, 3'b000);
      tick();
      chk($sformatf("v%0d_frame_valid", v), fv, vec[v].e_fv);
      chk($sformatf("v%0d_error", v), err, vec[v].e_err);
      chk($sformatf("v%0d_repeat", v), rep, vec[v].e_rep);
      tick();
      chk($sformatf("v%0d_count", v), count, vec[v].e_count);
      chk($sformatf("v%0d_seg", v), seg, exp_seg(vec[v].e_word, 1'b0));
      chk($sformatf("v%0d_pulses_n3", v), {fv, err, rep}, 3'b000);
      if (v == 0) begin
        chk("v0_digit0_D", seg[6:0], 7'h21);
        chk("v0_digit7_0", seg[55:49], 7'h40);
      end
      tick();
    end

    // Clear, then wrap the history and step through it
    mode  = 2'd3;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_count", count, 3'd0);
    chk("clear_seg_blank", seg, {8{7'h7F}});
    push(32'h00FF_01FE);
    push(32'h00FF_02FD);
    push(32'h00FF_03FC);
    push(32'h00FF_04FB);
    push(32'h00FF_05FA);
    tick();
    chk("wrap_count", count, 3'd4);
    chk("wrap_newest", seg, exp_seg(32'h00FF_05FA, 1'b0));
    for (int s = 0; s < 4; s++) begin
      sel_step = 1'b1;
      tick();
      sel_step = 1'b0;
      if (s == 0) begin
        chk("step_not_yet", seg, exp_seg(32'h00FF_05FA, 1'b0));
      end
      tick();
      chk($sformatf("step%0d", s), seg, exp_seg(step_exp[s], 1'b0));
    end

    // Mode change shows one cycle later (error count was cleared)
    mode = 2'd2;
    tick();
    chk("mode_change_n1", seg, exp_seg(32'h0000_0000, 1'b0));

    // Timeout blanking in mode 00, mode 11 unaffected
    mode = 2'd0;
    send(32'h00FF_06F9);
    tick();
    chk("tmo_commit", fv, 1'b1);
    repeat (TMO - 5) tick();
    chk("tmo_before", seg, exp_seg(32'h00FF_06F9, 1'b0));
    repeat (7) tick();
    chk("tmo_blank", seg, {8{7'h7F}});
    mode = 2'd3;
    tick();
    chk("tmo_mode11_shown", seg, exp_seg(32'h00FF_06F9, 1'b0));

    // Repeat within timeout, then same code after timeout is a new frame
    mode = 2'd0;
    send(32'h00FF_07F8);
    tick();
    chk("rep_first_fv", fv, 1'b1);
    repeat (50) tick();
    send(32'h00FF_07F8);
    tick();
    chk("rep_second_rep", rep, 1'b1);
    chk("rep_second_fv", fv, 1'b0);
    tick();
    chk("rep_count", count, 3'd4);
    chk("rep_seg", seg, exp_seg(32'h00FF_07F8, 1'b0));
    repeat (110) tick();
    send(32'h00FF_07F8);
    tick();
    chk("rep_expired_fv", fv, 1'b1);
    chk("rep_expired_rep", rep, 1'b0);
    tick();

    // Reset while in CHECK
    send(32'h00FF_08F7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstchk_pulses0", {fv, err, rep}, 3'b000);
    chk("rstchk_count", count, 3'd0);
    chk("rstchk_seg", seg, {8{7'h7F}});
    tick();
    chk("rstchk_pulses1", {fv, err, rep}, 3'b000);
    tick();
    chk("rstchk_pulses2", {fv, err, rep}, 3'b000);

    // Clear coincident with COMMIT
    mode = 2'd0;
    push(32'h00FF_09F6);
    chk("clrcommit_pre_count", count, 3'd1);
    send(32'h00FF_0AF5);
    tick();
    clear = 1'b1;
    #1;
    chk("clrcommit_no_fv", {fv, err, rep}, 3'b000);
    tick();
    clear = 1'b0;
    chk("clrcommit_count", count, 3'd0);
    chk("clrcommit_seg", seg, {8{7'h7F}});

    // Overrun: second frame while busy is dropped and flagged
    send(32'h00FF_0BF4);
    data       = 32'h00FF_0CF3;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    chk("ovr_first_fv", fv, 1'b1);
    chk("ovr_first_err", err, 1'b0);
    tick();
    chk("ovr_err_pulse", err, 1'b1);
    chk("ovr_count", count, 3'd1);
    mode = 2'd2;
    tick();
    chk("ovr_err_cnt", seg, exp_seg(32'h0000_0001, 1'b0));
    chk("ovr_err_gone", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
